// File: rtl/cntry_vehicle_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cntry_vehicle_detector
// Purpose  : Country-road sensor front end. Synchronises and debounces the
//            raw inductive-loop level, counts arrivals into a saturating
//            queue, retires one vehicle per DEPART_CYCLES GREEN cycles and
//            raises the car-present request X while vehicles are waiting.
// Ports    : clk        - system clock, rising edge
//            clear      - asynchronous active-high reset
//            loop_raw   - raw loop level, asynchronous to clk
//            cntry[1:0] - country light code (RED=0, YELLOW=1, GREEN=2)
//            X          - car-present request (queue non-empty)
//            queue_cnt  - vehicles currently waiting
//            overflow   - sticky: arrival seen while queue saturated
//            loop_fault - stuck-loop flag
// Options  : `define LOOP_FAULT_EN builds the stuck-loop detector; without it
//            loop_fault is constant 0 and X = (queue_cnt != 0).
// Revision : 1.0 - initial release
// ============================================================================
module cntry_vehicle_detector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPART_CYCLES   = 3,
  parameter int CNT_W           = 4,
  parameter int STUCK_CYCLES    = 64
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             loop_raw,
  input  logic [1:0]       cntry,
  output logic             X,
  output logic [CNT_W-1:0] queue_cnt,
  output logic             overflow,
  output logic             loop_fault
);

  localparam int         c_DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int         c_TMR_W  = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [1:0] c_GREEN  = 2'd2;
  localparam logic [CNT_W-1:0] c_Q_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_QUAL_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_QUAL_LO = 2'd3
  } deb_state_t;

  logic                r_sync1;
  logic                r_sync2;
  deb_state_t          r_state;
  logic [c_DCNT_W-1:0] r_dcnt;
  logic                r_deb;
  logic                r_arrive;
  logic [c_TMR_W-1:0]  r_dtmr;

  logic w_green;
  logic w_q_nz;
  logic w_serve;
  logic w_depart;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser on the asynchronous loop input.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= loop_raw;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM. r_dcnt holds the number of consecutive new-level samples
  // already accepted; the level flips on the sample that makes the run
  // DEBOUNCE_CYCLES long, so a run of DEBOUNCE_CYCLES-1 samples is rejected.
  // r_arrive is a registered one-cycle pulse for the first cycle of HIGH.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state  <= S_LOW;
      r_dcnt   <= '0;
      r_deb    <= 1'b0;
      r_arrive <= 1'b0;
    end else begin
      r_arrive <= 1'b0;
      case (r_state)
        S_LOW: begin
          if (r_sync2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state  <= S_HIGH;
              r_deb    <= 1'b1;
              r_arrive <= 1'b1;
            end else begin
              r_state <= S_QUAL_HI;
              r_dcnt  <= c_DCNT_W'(1);
            end
          end
        end
        S_QUAL_HI: begin
          if (!r_sync2) begin
            r_state <= S_LOW;
          end else if (r_dcnt == c_DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_state  <= S_HIGH;
            r_deb    <= 1'b1;
            r_arrive <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + c_DCNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!r_sync2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= S_LOW;
              r_deb   <= 1'b0;
            end else begin
              r_state <= S_QUAL_LO;
              r_dcnt  <= c_DCNT_W'(1);
            end
          end
        end
        S_QUAL_LO: begin
          if (r_sync2) begin
            r_state <= S_HIGH;
          end else if (r_dcnt == c_DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_state <= S_LOW;
            r_deb   <= 1'b0;
          end else begin
            r_dcnt <= r_dcnt + c_DCNT_W'(1);
          end
        end
        default: begin
          r_state <= S_LOW;
          r_deb   <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Departure timer. Runs only while GREEN with vehicles waiting; the
  // departure strobe is decoded from the timer so the first vehicle leaves on
  // the DEPART_CYCLES-th GREEN edge. Gating on w_q_nz guarantees no departure
  // is produced from an empty queue.
  // --------------------------------------------------------------------------
  assign w_green  = (cntry == c_GREEN);
  assign w_q_nz   = (queue_cnt != '0);
  assign w_serve  = w_green && w_q_nz;
  assign w_depart = w_serve && (r_dtmr == c_TMR_W'(DEPART_CYCLES - 1));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_dtmr <= '0;
    end else if (!w_serve || w_depart) begin
      r_dtmr <= '0;
    end else begin
      r_dtmr <= r_dtmr + c_TMR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Saturating queue counter with sticky overflow. A coincident arrival and
  // departure cancel out.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      queue_cnt <= '0;
      overflow  <= 1'b0;
    end else if (r_arrive && !w_depart) begin
      if (queue_cnt == c_Q_MAX) begin
        overflow <= 1'b1;
      end else begin
        queue_cnt <= queue_cnt + CNT_W'(1);
      end
    end else if (w_depart && !r_arrive) begin
      queue_cnt <= queue_cnt - CNT_W'(1);
    end
  end

`ifdef LOOP_FAULT_EN
  // --------------------------------------------------------------------------
  // Stuck-loop detector: counts cycles of debounced-high, flags a fault after
  // STUCK_CYCLES and holds it until the debounced level drops. While faulted
  // the request is forced so the country road keeps being served.
  // --------------------------------------------------------------------------
  localparam int c_FCNT_W = $clog2(STUCK_CYCLES + 1);

  logic [c_FCNT_W-1:0] r_fcnt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_fcnt     <= '0;
      loop_fault <= 1'b0;
    end else if (!r_deb) begin
      r_fcnt     <= '0;
      loop_fault <= 1'b0;
    end else if (r_fcnt != c_FCNT_W'(STUCK_CYCLES)) begin
      r_fcnt <= r_fcnt + c_FCNT_W'(1);
      if (r_fcnt == c_FCNT_W'(STUCK_CYCLES - 1)) begin
        loop_fault <= 1'b1;
      end
    end
  end

  assign X = w_q_nz || loop_fault;
`else
  // STUCK_CYCLES is always positive, so this is a constant 0; referencing it
  // keeps the parameter list meaningful in both builds.
  assign loop_fault = (STUCK_CYCLES < 0);
  assign X          = w_q_nz;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cntry_vehicle_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cntry_vehicle_detector
// Purpose  : Directed self-checking bench for cntry_vehicle_detector with
//            default parameters (DEBOUNCE 4, DEPART 3, CNT_W 4, STUCK 64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cntry_vehicle_detector;

  logic       clk = 1'b0;
  logic       clear;
  logic       loop_raw;
  logic [1:0] cntry;
  logic       X;
  logic [3:0] queue_cnt;
  logic       overflow;
  logic       loop_fault;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cntry_vehicle_detector #(
    .DEBOUNCE_CYCLES(4),
    .DEPART_CYCLES  (3),
    .CNT_W          (4),
    .STUCK_CYCLES   (64)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .loop_raw  (loop_raw),
    .cntry     (cntry),
    .X         (X),
    .queue_cnt (queue_cnt),
    .overflow  (overflow),
    .loop_fault(loop_fault)
  );

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clean vehicle: 6 cycles on the loop, 8 cycles gap.
  task automatic car();
    loop_raw = 1'b1;
    tick(6);
    loop_raw = 1'b0;
    tick(8);
  endtask

  task automatic test_reset();
    clear    = 1'b1;
    loop_raw = 1'b0;
    cntry    = 2'd0;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      loop_raw = ~loop_raw;
      tick(1);
    end
    loop_raw = 1'b0;
    n_checks++; if (X !== 1'b0) $display("FAIL reset_X: got %b expected 0", X); else n_pass++;
    n_checks++; if (queue_cnt !== 4'd0) $display("FAIL reset_q: got %0d expected 0", queue_cnt); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", overflow); else n_pass++;
    n_checks++; if (loop_fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", loop_fault); else n_pass++;
    clear = 1'b0;
    tick(2);
    n_checks++; if (queue_cnt !== 4'd0) $display("FAIL reset_release_q: got %0d expected 0", queue_cnt); else n_pass++;
  endtask

  task automatic test_single_car();
    cntry    = 2'd0;
    loop_raw = 1'b1;
    tick(6);
    n_checks++; if (queue_cnt !== 4'd0) $display("FAIL single_edge6_q: got %0d expected 0", queue_cnt); else n_pass++;
    tick(1);
    n_checks++; if (queue_cnt !== 4'd1) $display("FAIL single_edge7_q: got %0d expected 1", queue_cnt); else n_pass++;
    n_checks++; if (X !== 1'b1) $display("FAIL single_edge7_X: got %b expected 1", X); else n_pass++;
    tick(3);
    loop_raw = 1'b0;
    tick(10);
    n_checks++; if (queue_cnt !== 4'd1) $display("FAIL single_hold_q: got %0d expected 1", queue_cnt); else n_pass++;
    cntry = 2'd2;
    tick(2);
    n_checks++; if (queue_cnt !== 4'd1) $display("FAIL single_green2_q: got %0d expected 1", queue_cnt); else n_pass++;
    tick(1);
    n_checks++; if (queue_cnt !== 4'd0) $display("FAIL single_green3_q: got %0d expected 0", queue_cnt); else n_pass++;
    n_checks++; if (X !== 1'b0) $display("FAIL single_green3_X: got %b expected 0", X); else n_pass++;
    cntry = 2'd0;
  endtask

  task automatic test_glitch();
    loop_raw = 1'b1;
    tick(3);
    loop_raw = 1'b0;
    tick(12);
    n_checks++; if (queue_cnt !== 4'd0) $display("FAIL glitch_q: got %0d expected 0", queue_cnt); else n_pass++;
    n_checks++; if (X !== 1'b0) $display("FAIL glitch_X: got %b expected 0", X); else n_pass++;
  endtask

  task automatic test_simultaneous();
    cntry = 2'd0;
    car();
    car();
    n_checks++; if (queue_cnt !== 4'd2) $display("FAIL simul_setup_q: got %0d expected 2", queue_cnt); else n_pass++;
    // Arrival lands on edge 7 after the rise; GREEN from edge 5 departs on edge 7.
    loop_raw = 1'b1;
    tick(4);
    cntry = 2'd2;
    tick(3);
    n_checks++; if (queue_cnt !== 4'd2) $display("FAIL simul_coincide_q: got %0d expected 2", queue_cnt); else n_pass++;
    cntry    = 2'd0;
    loop_raw = 1'b0;
    tick(10);
    n_checks++; if (queue_cnt !== 4'd2) $display("FAIL simul_after_q: got %0d expected 2", queue_cnt); else n_pass++;
    // YELLOW interrupts the count: timer must restart from zero.
    cntry = 2'd2;
    tick(2);
    cntry = 2'd1;
    tick(1);
    cntry = 2'd2;
    tick(2);
    n_checks++; if (queue_cnt !== 4'd2) $display("FAIL yellow_reset_q: got %0d expected 2", queue_cnt); else n_pass++;
    tick(1);
    n_checks++; if (queue_cnt !== 4'd1) $display("FAIL yellow_depart_q: got %0d expected 1", queue_cnt); else n_pass++;
    // Illegal code 3 behaves like non-GREEN.
    tick(2);
    cntry = 2'd3;
    tick(1);
    cntry = 2'd2;
    tick(2);
    n_checks++; if (queue_cnt !== 4'd1) $display("FAIL illegal_reset_q: got %0d expected 1", queue_cnt); else n_pass++;
    tick(1);
    n_checks++; if (queue_cnt !== 4'd0) $display("FAIL illegal_depart_q: got %0d expected 0", queue_cnt); else n_pass++;
    n_checks++; if (X !== 1'b0) $display("FAIL illegal_depart_X: got %b expected 0", X); else n_pass++;
    cntry = 2'd0;
  endtask

  task automatic test_loop_fault();
    loop_raw = 1'b1;
    cntry    = 2'd2;
    tick(7);
    n_checks++; if (queue_cnt !== 4'd1) $display("FAIL fault_arrive_q: got %0d expected 1", queue_cnt); else n_pass++;
    n_checks++; if (X !== 1'b1) $display("FAIL fault_arrive_X: got %b expected 1", X); else n_pass++;
    tick(5);
    n_checks++; if (queue_cnt !== 4'd0) $display("FAIL fault_drain_q: got %0d expected 0", queue_cnt); else n_pass++;
    tick(57);
    n_checks++; if (loop_fault !== 1'b0) $display("FAIL fault_edge69: got %b expected 0", loop_fault); else n_pass++;
    tick(1);
`ifdef LOOP_FAULT_EN
    n_checks++; if (loop_fault !== 1'b1) $display("FAIL fault_edge70: got %b expected 1", loop_fault); else n_pass++;
    n_checks++; if (X !== 1'b1) $display("FAIL fault_edge70_X: got %b expected 1", X); else n_pass++;
`else
    n_checks++; if (loop_fault !== 1'b0) $display("FAIL fault_disabled: got %b expected 0", loop_fault); else n_pass++;
    n_checks++; if (X !== 1'b0) $display("FAIL fault_disabled_X: got %b expected 0", X); else n_pass++;
`endif
    tick(10);
    loop_raw = 1'b0;
    tick(6);
`ifdef LOOP_FAULT_EN
    n_checks++; if (loop_fault !== 1'b1) $display("FAIL fault_hold: got %b expected 1", loop_fault); else n_pass++;
`endif
    tick(1);
    n_checks++; if (loop_fault !== 1'b0) $display("FAIL fault_release: got %b expected 0", loop_fault); else n_pass++;
    n_checks++; if (X !== 1'b0) $display("FAIL fault_release_X: got %b expected 0", X); else n_pass++;
    n_checks++; if (queue_cnt !== 4'd0) $display("FAIL fault_final_q: got %0d expected 0", queue_cnt); else n_pass++;
    cntry = 2'd0;
  endtask

  task automatic test_saturation();
    cntry = 2'd0;
    for (int i = 0; i < 15; i++) car();
    n_checks++; if (queue_cnt !== 4'd15) $display("FAIL sat_15_q: got %0d expected 15", queue_cnt); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL sat_15_ovf: got %b expected 0", overflow); else n_pass++;
    car();
    n_checks++; if (queue_cnt !== 4'd15) $display("FAIL sat_16_q: got %0d expected 15", queue_cnt); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL sat_16_ovf: got %b expected 1", overflow); else n_pass++;
    cntry = 2'd2;
    tick(3);
    cntry = 2'd0;
    n_checks++; if (queue_cnt !== 4'd14) $display("FAIL sat_depart_q: got %0d expected 14", queue_cnt); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL sat_depart_ovf: got %b expected 1", overflow); else n_pass++;
  endtask

  task automatic test_async_clear();
    // Assert clear between edges; outputs must drop before the next edge.
    #3;
    clear    = 1'b1;
    loop_raw = 1'b1;
    #1;
    n_checks++; if (queue_cnt !== 4'd0) $display("FAIL aclr_q: got %0d expected 0", queue_cnt); else n_pass++;
    n_checks++; if (X !== 1'b0) $display("FAIL aclr_X: got %b expected 0", X); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL aclr_ovf: got %b expected 0", overflow); else n_pass++;
    tick(1);
    clear = 1'b0;
    // Loop still high: re-qualifies as exactly one new arrival.
    tick(6);
    n_checks++; if (queue_cnt !== 4'd0) $display("FAIL aclr_requal6_q: got %0d expected 0", queue_cnt); else n_pass++;
    tick(1);
    n_checks++; if (queue_cnt !== 4'd1) $display("FAIL aclr_requal7_q: got %0d expected 1", queue_cnt); else n_pass++;
    tick(10);
    n_checks++; if (queue_cnt !== 4'd1) $display("FAIL aclr_single_q: got %0d expected 1", queue_cnt); else n_pass++;
    loop_raw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_car();
    test_glitch();
    test_simultaneous();
    test_loop_fault();
    test_saturation();
    test_async_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
